mcu_cmd_dispatcher: RTL

- Multi-channel successor of the single-channel MCU command controller.
- Decodes 32-bit GPIO command words from the soft MCU and services NUM_ENC rotary encoders (read-and-clear) and NUM_DDS phase-increment registers (split 24-bit writes, readback).
- Uses a toggle-based request/acknowledge handshake, so back-to-back identical commands need no intervening NO_COMMAND.
- Each phase_inc_valid is stretched so slower-clocked DDS cores sample it.

---
 rtl/mcu_cmd_pkg.sv | 42 ++++
 rtl/pulse_stretch.sv | 27 ++
 rtl/mcu_cmd_dispatcher.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mcu_cmd_pkg.sv
// Shared definitions for the MCU command dispatcher: command/response word layout,
// opcodes, status codes and FSM state encodings.
package mcu_cmd_pkg;

    localparam int REQ_BIT     = 31;
    localparam int OP_MSB      = 30;
    localparam int OP_LSB      = 28;
    localparam int CH_MSB      = 27;
    localparam int CH_LSB      = 24;
    localparam int PAYLOAD_MSB = 23;

    localparam int ACK_BIT  = 31;
    localparam int STAT_MSB = 30;
    localparam int STAT_LSB = 28;
    localparam int DATA_MSB = 27;

    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_GET_ENC      = 3'd1,
        OP_SET_PHASE_LO = 3'd2,
        OP_SET_PHASE_HI = 3'd3,
        OP_GET_PHASE_LO = 3'd4,
        OP_GET_PHASE_HI = 3'd5,
        OP_GET_INFO     = 3'd6,
        OP_RSVD         = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_OK          = 3'd0,
        ST_BAD_CHANNEL = 3'd1,
        ST_BAD_OPCODE  = 3'd2,
        ST_TIMEOUT     = 3'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_WAIT_ENC = 2'd2,
        S_RESP     = 2'd3
    } state_e;

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: output high for exactly CYCLES cycles after the
// last trigger, so slower-clocked consumers see the strobe.
module pulse_stretch #(
    parameter int CYCLES = 16
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic trig,
    output logic pulse
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (trig) begin
            cnt <= CW'(CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign pulse = (cnt != '0);

endmodule

// File: rtl/mcu_cmd_dispatcher.sv
// Decodes toggle-handshaked MCU command words and services encoder reads and
// split DDS phase-increment writes/readbacks.
//
// state      | meaning
// S_IDLE     | waiting for req toggle to differ from seq_last; latch word
// S_EXEC     | validate channel/opcode, perform side effect, form response
// S_WAIT_ENC | encoder read enable held, waiting for enc_valid or timeout
// S_RESP     | drive to_mcu with ack toggle, status, data
module mcu_cmd_dispatcher
    import mcu_cmd_pkg::*;
#(
    parameter int          NUM_ENC         = 2,
    parameter int          NUM_DDS         = 2,
    parameter int          PHASE_INC_WIDTH = 27,
    parameter int unsigned PHASE_INC_RESET = 8388608,
    parameter int          VALID_CYCLES    = 16,
    parameter int          ENC_TIMEOUT     = 1024
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [31:0]                        from_mcu,
    output logic [31:0]                        to_mcu,
    output logic [NUM_ENC-1:0]                 enc_read_enable,
    input  logic [8*NUM_ENC-1:0]               enc_change,
    input  logic [NUM_ENC-1:0]                 enc_valid,
    output logic [PHASE_INC_WIDTH*NUM_DDS-1:0] phase_inc,
    output logic [NUM_DDS-1:0]                 phase_inc_valid,
    output logic                               busy
);
    localparam int W  = PHASE_INC_WIDTH;
    localparam int TW = $clog2(ENC_TIMEOUT + 1);
    localparam logic [4:0]   ENC_LIM   = 5'(NUM_ENC);
    localparam logic [4:0]   DDS_LIM   = 5'(NUM_DDS);
    localparam logic [W-1:0] PHASE_RST = W'(PHASE_INC_RESET);
    localparam logic [27:0]  INFO_WORD = {4'(NUM_ENC - 1), 4'(NUM_DDS - 1), 14'b0, 6'(W)};

    state_e      state, state_d;
    logic [31:0] cmd_q;
    logic        seq_last;
    logic [TW-1:0] timer;
    status_e     resp_status, st_d;
    logic [27:0] resp_data, data_d;
    logic [23:0]  stage_q [NUM_DDS];
    logic [W-1:0] phase_q [NUM_DDS];

    opcode_e      op;
    logic [3:0]   ch;
    logic [23:0]  payload;
    logic         enc_ch_ok, dds_ch_ok, sel_valid;
    logic [7:0]   sel_change;
    logic [W-1:0] sel_phase;
    logic [NUM_ENC-1:0] enc_sel;
    logic [NUM_DDS-1:0] dds_sel, commit;
    logic latch, wr_lo, wr_hi, rd_start, rd_done, set_resp, send;

    assign op        = opcode_e'(cmd_q[OP_MSB:OP_LSB]);
    assign ch        = cmd_q[CH_MSB:CH_LSB];
    assign payload   = cmd_q[PAYLOAD_MSB:0];
    assign enc_ch_ok = ({1'b0, ch} < ENC_LIM);
    assign dds_ch_ok = ({1'b0, ch} < DDS_LIM);
    assign busy      = (state != S_IDLE);

    // Channel selects by loop compare so out-of-range channels select nothing.
    always_comb begin
        enc_sel    = '0;
        sel_valid  = 1'b0;
        sel_change = '0;
        for (int i = 0; i < NUM_ENC; i++) begin
            enc_sel[i] = (ch == 4'(i));
            if (enc_sel[i]) begin
                sel_valid  = enc_valid[i];
                sel_change = enc_change[8*i +: 8];
            end
        end
    end

    always_comb begin
        dds_sel   = '0;
        sel_phase = '0;
        for (int i = 0; i < NUM_DDS; i++) begin
            dds_sel[i] = (ch == 4'(i));
            if (dds_sel[i]) sel_phase = phase_q[i];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d  = state;
        latch    = 1'b0;
        wr_lo    = 1'b0;
        wr_hi    = 1'b0;
        rd_start = 1'b0;
        rd_done  = 1'b0;
        set_resp = 1'b0;
        send     = 1'b0;
        st_d     = ST_OK;
        data_d   = '0;
        case (state)
            S_IDLE: begin
                if (from_mcu[REQ_BIT] != seq_last) begin
                    latch   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d  = S_RESP;
                set_resp = 1'b1;
                case (op)
                    OP_NOP: ;
                    OP_GET_ENC: begin
                        if (enc_ch_ok) begin
                            rd_start = 1'b1;
                            set_resp = 1'b0;
                            state_d  = S_WAIT_ENC;
                        end else st_d = ST_BAD_CHANNEL;
                    end
                    OP_SET_PHASE_LO: if (dds_ch_ok) wr_lo = 1'b1; else st_d = ST_BAD_CHANNEL;
                    OP_SET_PHASE_HI: if (dds_ch_ok) wr_hi = 1'b1; else st_d = ST_BAD_CHANNEL;
                    OP_GET_PHASE_LO: begin
                        if (dds_ch_ok) data_d = {4'b0, sel_phase[23:0]};
                        else           st_d   = ST_BAD_CHANNEL;
                    end
                    OP_GET_PHASE_HI: begin
                        if (dds_ch_ok) data_d = 28'(sel_phase[W-1:24]);
                        else           st_d   = ST_BAD_CHANNEL;
                    end
                    OP_GET_INFO: data_d = INFO_WORD;
                    default:     st_d   = ST_BAD_OPCODE;
                endcase
            end
            S_WAIT_ENC: begin
                // Valid wins over an expiring timer in the same cycle.
                if (sel_valid) begin
                    rd_done  = 1'b1;
                    set_resp = 1'b1;
                    data_d   = {{20{sel_change[7]}}, sel_change};
                    state_d  = S_RESP;
                end else if (timer == '0) begin
                    rd_done  = 1'b1;
                    set_resp = 1'b1;
                    st_d     = ST_TIMEOUT;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                send    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cmd_q           <= '0;
            seq_last        <= 1'b0;
            to_mcu          <= '0;
            timer           <= '0;
            resp_status     <= ST_OK;
            resp_data       <= '0;
            enc_read_enable <= '0;
            for (int i = 0; i < NUM_DDS; i++) begin
                stage_q[i] <= '0;
                phase_q[i] <= PHASE_RST;
            end
        end else begin
            if (latch) cmd_q <= from_mcu;
            if (set_resp) begin
                resp_status <= st_d;
                resp_data   <= data_d;
            end
            if (rd_start) begin
                enc_read_enable <= enc_sel;
                timer           <= TW'(ENC_TIMEOUT - 1);
            end else if (state == S_WAIT_ENC && timer != '0) begin
                timer <= timer - TW'(1);
            end
            if (rd_done) enc_read_enable <= '0;
            if (send) begin
                to_mcu[ACK_BIT]           <= cmd_q[REQ_BIT];
                to_mcu[STAT_MSB:STAT_LSB] <= resp_status;
                to_mcu[DATA_MSB:0]        <= resp_data;
                seq_last                  <= cmd_q[REQ_BIT];
            end
            for (int i = 0; i < NUM_DDS; i++) begin
                if (wr_lo && dds_sel[i]) stage_q[i] <= payload;
                if (wr_hi && dds_sel[i]) phase_q[i] <= {payload[W-25:0], stage_q[i]};
            end
        end
    end

    assign commit = wr_hi ? dds_sel : '0;

    for (genvar g = 0; g < NUM_DDS; g++) begin : g_dds
        assign phase_inc[g*W +: W] = phase_q[g];

        pulse_stretch #(.CYCLES(VALID_CYCLES)) u_stretch (
            .aclk    (aclk),
            .aresetn (aresetn),
            .trig    (commit[g]),
            .pulse   (phase_inc_valid[g])
        );
    end

endmodule
